// File: rtl/ascii_index_decoder_if.sv
// Character-in / index-out streaming bus for the ASCII index decoder.
// The decoder connects as slave; the producer/consumer side connects as master.
interface ascii_index_decoder_if #(
  parameter int OUT_WIDTH = 10
);
  logic [7:0]           in_char;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_index;
  logic                 out_error;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready,
    input  out_index,
    input  out_error,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready,
    output out_index,
    output out_error,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/ascii_index_decoder.sv
// Streaming decoder: a fixed-width, zero-padded ASCII decimal field
// (most significant character first) is folded into a binary index.
// Field boundaries come only from the character count; there is no terminator.
module ascii_index_decoder #(
  parameter int MAX_DIGITS = 3,
  parameter int OUT_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascii_index_decoder_if.slave bus
);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Bits needed to hold any value strictly below 'value' (at least 1).
  function automatic int clog2_width(input longint value);
    int w;
    w = 1;
    while ((longint'(1) << w) < value) w++;
    return w;
  endfunction

  localparam int ACC_WIDTH = clog2_width(pow10(MAX_DIGITS) + 1);
  localparam int CNT_W     = clog2_width(longint'(MAX_DIGITS) + 1);
  localparam int CMP_W     = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DIGITS - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] OUT   = 1'b1;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [3:0] char_digit(input logic [7:0] c);
    logic [7:0] diff;
    diff = c - 8'h30;
    return diff[3:0];
  endfunction

  // True when the accumulated value cannot be represented in OUT_WIDTH bits.
  function automatic logic exceeds_out(input logic [ACC_WIDTH-1:0] v);
    logic [CMP_W-1:0] ext;
    ext = CMP_W'(v);
    return (ext >> OUT_WIDTH) != '0;
  endfunction

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 bad_char;
  logic [OUT_WIDTH-1:0] index_q;
  logic                 error_q;

  logic                 char_ok;
  logic [ACC_WIDTH-1:0] acc_mul10;
  logic [ACC_WIDTH-1:0] acc_upd;
  logic                 bad_upd;
  logic                 final_err;

  // Next accumulator value for the character currently on the bus; *10 as shift-add.
  always_comb begin
    char_ok   = is_digit(bus.in_char);
    acc_mul10 = (acc << 3) + (acc << 1);
    acc_upd   = acc;
    if (char_ok) acc_upd = acc_mul10 + ACC_WIDTH'(char_digit(bus.in_char));
    bad_upd   = bad_char | ~char_ok;
    final_err = bad_upd | exceeds_out(acc_upd);
  end

  // Field accumulation, result capture on the last character, and hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      bad_char <= 1'b0;
      index_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc      <= acc_upd;
            bad_char <= bad_upd;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state   <= OUT;
              error_q <= final_err;
              index_q <= final_err ? '0 : OUT_WIDTH'(acc_upd);
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            bad_char <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == OUT);
  assign bus.out_index = index_q;
  assign bus.out_error = error_q;

endmodule

// File: tb/tb_ascii_index_decoder.sv
// Directed bench for ascii_index_decoder: a 10-bit and a 9-bit instance
// receive identical stimulus so the overflow boundary can be observed.
module tb_ascii_index_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_char;
  logic       in_valid;
  logic       out_ready;

  int checks;
  int errors;
  int xfer_cnt;

  ascii_index_decoder_if #(.OUT_WIDTH(10)) bus10 ();
  ascii_index_decoder_if #(.OUT_WIDTH(9))  bus9 ();

  assign bus10.in_char   = in_char;
  assign bus10.in_valid  = in_valid;
  assign bus10.out_ready = out_ready;
  assign bus9.in_char    = in_char;
  assign bus9.in_valid   = in_valid;
  assign bus9.out_ready  = out_ready;

  ascii_index_decoder #(.MAX_DIGITS(3), .OUT_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10)
  );

  ascii_index_decoder #(.MAX_DIGITS(3), .OUT_WIDTH(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output transfers of the 10-bit instance, observed mid-cycle before the edge.
  always @(negedge clk) begin
    if (rst_n && bus10.out_valid && out_ready) xfer_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (bus10.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout char=%02h in_ready stayed %b, required 1", c, bus10.in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus10.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus10.out_valid);
    end
    checks++;
    if (bus10.out_index !== 10'd0 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got idx=%0d err=%b want idx=0 err=0", bus10.out_index, bus10.out_error);
    end
    checks++;
    if (bus10.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus10.in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    send_char("0");
    send_char("4");
    checks++;
    if (bus10.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %b want 0", bus10.out_valid);
    end
    send_char("2");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd42 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got vld=%b idx=%0d err=%b want vld=1 idx=42 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    step();
    checks++;
    if (bus10.in_ready !== 1'b1 || bus10.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got rdy=%b vld=%b want rdy=1 vld=0", bus10.in_ready, bus10.out_valid);
    end
  endtask

  task automatic test_overflow();
    send_char("9");
    send_char("9");
    send_char("9");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd999 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_w10 got vld=%b idx=%0d err=%b want vld=1 idx=999 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    checks++;
    if (bus9.out_valid !== 1'b1 || bus9.out_index !== 9'd0 || bus9.out_error !== 1'b1) begin
      errors++;
      $display("FAIL ovf_w9 got vld=%b idx=%0d err=%b want vld=1 idx=0 err=1",
               bus9.out_valid, bus9.out_index, bus9.out_error);
    end
    step();
  endtask

  task automatic test_bad_char();
    send_char("1");
    send_char(":");
    send_char("3");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd0 || bus10.out_error !== 1'b1) begin
      errors++;
      $display("FAIL badchar_result got vld=%b idx=%0d err=%b want vld=1 idx=0 err=1",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    step();
    send_char("0");
    send_char("0");
    send_char("7");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd7 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL badchar_noleak got vld=%b idx=%0d err=%b want vld=1 idx=7 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    checks++;
    if (bus9.out_index !== 9'd7 || bus9.out_error !== 1'b0) begin
      errors++;
      $display("FAIL badchar_noleak_w9 got idx=%0d err=%b want idx=7 err=0", bus9.out_index, bus9.out_error);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_char("1");
    send_char("2");
    send_char("3");
    in_char  = "7";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd123 || bus10.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got vld=%b idx=%0d rdy=%b want vld=1 idx=123 rdy=0",
                 i, bus10.out_valid, bus10.out_index, bus10.in_ready);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (bus10.out_valid !== 1'b0 || bus10.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got vld=%b rdy=%b want vld=0 rdy=1", bus10.out_valid, bus10.in_ready);
    end
    send_char("0");
    send_char("0");
    send_char("1");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd1 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL stall_next got vld=%b idx=%0d err=%b want vld=1 idx=1 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    step();
  endtask

  task automatic test_gaps();
    int start;
    int early;
    start = xfer_cnt;
    early = 0;
    send_char("1");
    for (int i = 0; i < 3; i++) begin
      if (bus10.out_valid !== 1'b0) early++;
      step();
    end
    send_char("2");
    if (bus10.out_valid !== 1'b0) early++;
    step();
    if (bus10.out_valid !== 1'b0) early++;
    send_char("3");
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL gaps_early_valid got %0d early cycles want 0", early);
    end
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd123 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result got vld=%b idx=%0d err=%b want vld=1 idx=123 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    step();
    step();
    checks++;
    if (xfer_cnt - start != 1) begin
      errors++;
      $display("FAIL gaps_count got %0d results want 1", xfer_cnt - start);
    end
  endtask

  task automatic test_mid_reset();
    int start;
    start = xfer_cnt;
    send_char("5");
    send_char("6");
    rst_n = 1'b0;
    step();
    checks++;
    if (bus10.out_valid !== 1'b0 || bus10.out_index !== 10'd0 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during got vld=%b idx=%0d err=%b want 0 0 0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus10.out_valid !== 1'b0 || bus10.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after got vld=%b rdy=%b want vld=0 rdy=1", bus10.out_valid, bus10.in_ready);
    end
    send_char("0");
    send_char("0");
    send_char("1");
    checks++;
    if (bus10.out_valid !== 1'b1 || bus10.out_index !== 10'd1 || bus10.out_error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result got vld=%b idx=%0d err=%b want vld=1 idx=1 err=0",
               bus10.out_valid, bus10.out_index, bus10.out_error);
    end
    step();
    step();
    checks++;
    if (xfer_cnt - start != 1) begin
      errors++;
      $display("FAIL midrst_count got %0d results want 1", xfer_cnt - start);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    xfer_cnt  = 0;
    rst_n     = 1'b0;
    in_char   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_bad_char();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
